fifo_write_packer: RTL and testbench

//  Write-side front end for the dual-clock FIFOs. Packs a narrow valid/ready

---
 rtl/fifo_write_packer.sv | 148 ++++++++++++++
 tb/tb_fifo_write_packer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_packer.sv
// fifo_write_packer: write-side front end for the dual-clock FIFOs.
// Collects narrow input beats into RATIO-lane words with a lane-valid mask.
// Completed words wait in a two-entry holding buffer, then drain into the
// FIFO whenever almostFull is low. Everything runs on wrclk.
module fifo_write_packer #(
    parameter  int IN_WIDTH  = 8,
    parameter  int RATIO     = 4,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO,
    localparam int LW        = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                 wrclk,
    input  logic                 rst,
    input  logic                 inValid,
    input  logic [IN_WIDTH-1:0]  inData,
    input  logic                 inLast,
    output logic                 inReady,
    input  logic                 almostFull,
    output logic                 writeEnable,
    output logic [OUT_WIDTH-1:0] dataOut,
    output logic [RATIO-1:0]     laneMask,
    output logic                 partialBusy,
    output logic [31:0]          wordCount
);

    // Packing state
    logic [LW-1:0]        lane_idx_q,  lane_idx_d;
    logic [OUT_WIDTH-1:0] part_data_q, part_data_d;
    logic [RATIO-1:0]     part_mask_q, part_mask_d;

    // Holding buffer; entry 0 is always the oldest word
    logic [OUT_WIDTH-1:0] hold_data_q [2];
    logic [OUT_WIDTH-1:0] hold_data_d [2];
    logic [RATIO-1:0]     hold_mask_q [2];
    logic [RATIO-1:0]     hold_mask_d [2];
    logic [1:0]           hold_count_q, hold_count_d;

    // Registered FIFO-side outputs
    logic                 write_enable_q, write_enable_d;
    logic [OUT_WIDTH-1:0] data_out_q,     data_out_d;
    logic [RATIO-1:0]     lane_mask_q,    lane_mask_d;
    logic [31:0]          word_count_q,   word_count_d;

    logic                 accept;
    logic                 complete;
    logic                 pop;
    logic [1:0]           wr_idx;
    logic [RATIO-1:0]     lane_sel;
    logic [OUT_WIDTH-1:0] word_data;
    logic [RATIO-1:0]     word_mask;

    // Ready depends only on registered state and reset, never on inValid
    assign inReady     = !rst && (hold_count_q != 2'd2);
    assign accept      = inValid && inReady;
    assign complete    = accept && (inLast || (lane_idx_q == LW'(RATIO - 1)));
    assign pop         = (hold_count_q != 2'd0) && !almostFull;
    // A word pushed while another pops lands behind the remaining entry
    assign wr_idx      = hold_count_q - 2'(pop);
    assign partialBusy = (lane_idx_q != '0);

    // The current word with this cycle's beat merged into its lane
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
        assign lane_sel[gi] = accept && (lane_idx_q == LW'(gi));
        assign word_data[gi*IN_WIDTH +: IN_WIDTH] =
            lane_sel[gi] ? inData : part_data_q[gi*IN_WIDTH +: IN_WIDTH];
        assign word_mask[gi] = lane_sel[gi] | part_mask_q[gi];
    end

    // Next-state: lane counter, partial word, holding buffer and outputs
    always_comb begin
        lane_idx_d     = lane_idx_q;
        part_data_d    = part_data_q;
        part_mask_d    = part_mask_q;
        hold_data_d    = hold_data_q;
        hold_mask_d    = hold_mask_q;
        hold_count_d   = hold_count_q + 2'(complete) - 2'(pop);
        write_enable_d = pop;
        data_out_d     = data_out_q;
        lane_mask_d    = lane_mask_q;
        word_count_d   = word_count_q;

        if (accept) begin
            if (complete) begin
                lane_idx_d  = '0;
                part_data_d = '0;
                part_mask_d = '0;
            end else begin
                lane_idx_d  = lane_idx_q + LW'(1);
                part_data_d = word_data;
                part_mask_d = word_mask;
            end
        end

        if (pop) begin
            data_out_d     = hold_data_q[0];
            lane_mask_d    = hold_mask_q[0];
            word_count_d   = word_count_q + 32'd1;
            hold_data_d[0] = hold_data_q[1];
            hold_mask_d[0] = hold_mask_q[1];
            hold_data_d[1] = '0;
            hold_mask_d[1] = '0;
        end

        if (complete) begin
            if (wr_idx == 2'd0) begin
                hold_data_d[0] = word_data;
                hold_mask_d[0] = word_mask;
            end else begin
                hold_data_d[1] = word_data;
                hold_mask_d[1] = word_mask;
            end
        end
    end

    // State registers; reset discards partial and queued words
    always_ff @(posedge wrclk) begin
        if (rst) begin
            lane_idx_q     <= '0;
            part_data_q    <= '0;
            part_mask_q    <= '0;
            hold_data_q[0] <= '0;
            hold_data_q[1] <= '0;
            hold_mask_q[0] <= '0;
            hold_mask_q[1] <= '0;
            hold_count_q   <= 2'd0;
            write_enable_q <= 1'b0;
            data_out_q     <= '0;
            lane_mask_q    <= '0;
            word_count_q   <= 32'd0;
        end else begin
            lane_idx_q     <= lane_idx_d;
            part_data_q    <= part_data_d;
            part_mask_q    <= part_mask_d;
            hold_data_q    <= hold_data_d;
            hold_mask_q    <= hold_mask_d;
            hold_count_q   <= hold_count_d;
            write_enable_q <= write_enable_d;
            data_out_q     <= data_out_d;
            lane_mask_q    <= lane_mask_d;
            word_count_q   <= word_count_d;
        end
    end

    assign writeEnable = write_enable_q;
    assign dataOut     = data_out_q;
    assign laneMask    = lane_mask_q;
    assign wordCount   = word_count_q;

endmodule

// File: tb/tb_fifo_write_packer.sv
// Bench for fifo_write_packer: directed scenarios plus a long random run,
// all checked against a queue-based model of completed words.
module tb_fifo_write_packer;

    localparam int IW = 8;
    localparam int R  = 4;
    localparam int OW = IW * R;

    typedef struct packed {
        logic [OW-1:0] d;
        logic [R-1:0]  m;
    } word_t;

    logic          wrclk;
    logic          rst;
    logic          inValid;
    logic [IW-1:0] inData;
    logic          inLast;
    logic          inReady;
    logic          almostFull;
    logic          writeEnable;
    logic [OW-1:0] dataOut;
    logic [R-1:0]  laneMask;
    logic          partialBusy;
    logic [31:0]   wordCount;

    fifo_write_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
        .wrclk       (wrclk),
        .rst         (rst),
        .inValid     (inValid),
        .inData      (inData),
        .inLast      (inLast),
        .inReady     (inReady),
        .almostFull  (almostFull),
        .writeEnable (writeEnable),
        .dataOut     (dataOut),
        .laneMask    (laneMask),
        .partialBusy (partialBusy),
        .wordCount   (wordCount)
    );

    initial wrclk = 1'b0;
    always #5 wrclk = ~wrclk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;

    // Model: beats of the word being filled, and completed words not yet written
    logic [IW-1:0] part_m [$];
    word_t         exp_q  [$];
    logic [OW-1:0] last_d;
    logic [R-1:0]  last_m;
    logic [31:0]   wc_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic word_t make_word();
        word_t w;
        w.d = '0;
        w.m = '0;
        for (int i = 0; i < part_m.size(); i++) begin
            w.d[i*IW +: IW] = part_m[i];
            w.m[i] = 1'b1;
        end
        return w;
    endfunction

    // One clock cycle: drive at the falling edge, predict, then check at the next falling edge
    task automatic step(input bit v, input logic [IW-1:0] d, input bit l, input bit a, input bit r);
        bit    exp_we;
        bit    acc;
        word_t w;
        inValid    = v;
        inData     = d;
        inLast     = l;
        almostFull = a;
        rst        = r;
        #1;
        exp_we = !r && (exp_q.size() > 0) && !a;
        acc    = v && inReady;
        if (r) begin
            exp_q.delete();
            part_m.delete();
            wc_m   = 32'd0;
            last_d = '0;
            last_m = '0;
        end else if (acc) begin
            part_m.push_back(d);
            if (l || part_m.size() == R) begin
                exp_q.push_back(make_word());
                part_m.delete();
            end
        end
        @(posedge wrclk);
        @(negedge wrclk);
        check("write_enable", 64'(writeEnable), 64'(exp_we));
        if (a) check("af_block", 64'(writeEnable), 64'd0);
        if (exp_we) begin
            w      = exp_q.pop_front();
            last_d = w.d;
            last_m = w.m;
            wc_m   = wc_m + 32'd1;
            n_writes++;
            $display("write %0d: data=0x%08h mask=%b count=%0h", n_writes, dataOut, laneMask, wordCount);
        end
        check("data_out", 64'(dataOut), 64'(last_d));
        check("lane_mask", 64'(laneMask), 64'(last_m));
        check("word_count", 64'(wordCount), 64'(wc_m));
        check("in_ready", 64'(inReady), 64'(!r && exp_q.size() != 2));
        check("partial_busy", 64'(partialBusy), 64'(part_m.size() != 0));
    endtask

    task automatic idle(input int n, input bit a);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, a, 1'b0);
    endtask

    initial begin
        logic [IW-1:0] d;
        rst        = 1'b1;
        inValid    = 1'b0;
        inData     = '0;
        inLast     = 1'b0;
        almostFull = 1'b0;
        wc_m       = 32'd0;
        last_d     = '0;
        last_m     = '0;
        @(negedge wrclk);

        // Reset state
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("rst_we", 64'(writeEnable), 64'd0);
        check("rst_count", 64'(wordCount), 64'd0);

        // Full word back-to-back
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        check("t1_no_early_write", 64'(writeEnable), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("t1_data", 64'(dataOut), 64'h44332211);
        check("t1_mask", 64'(laneMask), 64'hF);
        check("t1_count", 64'(wordCount), 64'd1);
        idle(2, 1'b0);

        // Flushed partial word, then next beat starts at lane 0
        step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
        check("t2_data", 64'(dataOut), 64'h0000A2A1);
        check("t2_mask", 64'(laneMask), 64'h3);
        step(1'b1, 8'hB1, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);
        check("t2_b_data", 64'(dataOut), 64'h0000B1B0);

        // Single-lane word
        step(1'b1, 8'hC5, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        check("single_lane_mask", 64'(laneMask), 64'h1);

        // almostFull held while 12 beats are offered
        for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b1, 1'b0);
        check("t3_stall_ready", 64'(inReady), 64'd0);
        check("t3_queued", 64'(exp_q.size()), 64'd2);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);

        // Long random run with almostFull toggling every 3 cycles
        for (int i = 0; i < 1000; i++) begin
            d = 8'($urandom);
            step(1'b1, d, ($urandom_range(0, 7) == 0), ((i / 3) % 2) == 1, 1'b0);
        end
        step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b0);

        // Reset with one queued word and a word filled to lane 2
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b1, 1'b0);
        check("t5_pre_busy", 64'(partialBusy), 64'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t5_we", 64'(writeEnable), 64'd0);
        check("t5_count", 64'(wordCount), 64'd0);
        check("t5_busy", 64'(partialBusy), 64'd0);
        idle(4, 1'b0);
        check("t5_no_leak", 64'(dataOut), 64'd0);

        // Push and pop in the same cycle, one word already queued
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h87, 1'b0, 1'b0, 1'b0);
        check("t6_hold_one", 64'(exp_q.size()), 64'd1);
        check("t6_first", 64'(dataOut), 64'h83828180);
        idle(2, 1'b0);
        check("t6_second", 64'(dataOut), 64'h87868584);

        // Word counter wrap
        force dut.word_count_q = 32'hFFFF_FFFF;
        wc_m = 32'hFFFF_FFFF;
        idle(1, 1'b0);
        release dut.word_count_q;
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        check("wrap_count", 64'(wordCount), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
